// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if
//   Control/status bundle for the programmable clock divider.
//   en          run request (level)
//   div         requested divide ratio N
//   div_load    one-cycle strobe capturing div
//   div_clk     divided clock output
//   tick        one-cycle pulse in the first source cycle of each div_clk period
//   div_active  ratio currently applied
//   load_err    one-cycle pulse after a rejected load (div < 2)
//   master: drives control, observes status.  slave: the divider itself.
interface clk_div_prog_if #(
  parameter int DIV_W = 8
) ();
  logic             en;
  logic [DIV_W-1:0] div;
  logic             div_load;
  logic             div_clk;
  logic             tick;
  logic [DIV_W-1:0] div_active;
  logic             load_err;

  modport master (
    output en, div, div_load,
    input  div_clk, tick, div_active, load_err
  );

  modport slave (
    input  en, div, div_load,
    output div_clk, tick, div_active, load_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog
//   Runtime-programmable integer clock divider, div_clk = clk / N with
//   N in [2, 2^DIV_W-1] and 50% duty for both even and odd N. Ratio changes
//   and start/stop take effect only on period boundaries so div_clk never
//   produces a runt pulse (except on asynchronous reset).
// Ports
//   clk    source clock; both edges are used (negedge for the odd-N stage)
//   rst_n  asynchronous active-low reset
//   bus    clk_div_prog_if.slave: en, div, div_load in; div_clk, tick,
//          div_active, load_err out
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input logic          clk,
  input logic          rst_n,
  clk_div_prog_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_act, div_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic [DIV_W-1:0] pend_div, pend_div_nxt;
  logic             start;
  logic             load_ok;
  logic             have_pend;
  logic [DIV_W-1:0] pend_val;
  logic             last;
  logic             run_nxt;
  logic [DIV_W-1:0] half_nxt;
  logic             p_even_nxt, p_odd_nxt;

  logic             p_even;   // even-N high phase, posedge aligned
  logic             p_odd;    // odd-N stage P: high cnt 0..(N-1)/2
  logic             q;        // odd-N stage Q: P delayed half a cycle
  logic             tick;
  logic             load_err;

  // A load in the same cycle as a boundary must still make that boundary,
  // so the incoming value bypasses the pending register.
  assign load_ok   = bus.div_load && (bus.div >= DIV_W'(2));
  assign have_pend = pend_vld || load_ok;
  assign pend_val  = load_ok ? bus.div : pend_div;
  assign last      = (cnt == div_act - 1'b1);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    div_nxt      = div_act;
    pend_vld_nxt = pend_vld;
    pend_div_nxt = pend_div;
    start        = 1'b0;

    if (load_ok) begin
      pend_vld_nxt = 1'b1;
      pend_div_nxt = bus.div;
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (have_pend) begin
          div_nxt      = pend_val;
          pend_vld_nxt = 1'b0;
        end
        if (bus.en) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (last) begin
          cnt_nxt = '0;
          // Ratio update happens on the boundary even when stopping, so a
          // later restart picks up the new ratio.
          if (have_pend) begin
            div_nxt      = pend_val;
            pend_vld_nxt = 1'b0;
          end
          if (bus.en) begin
            state_nxt = RUN;
            start     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = bus.en ? RUN : STOPPING;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Phase registers are loaded from the next-state view so div_clk rises
    // on the same edge that starts the period.
    run_nxt    = (state_nxt != IDLE);
    half_nxt   = div_nxt >> 1;
    p_even_nxt = run_nxt && !div_nxt[0] && (cnt_nxt <  half_nxt);
    p_odd_nxt  = run_nxt &&  div_nxt[0] && (cnt_nxt <= half_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_act  <= DIV_W'(DEFAULT_DIV);
      pend_vld <= 1'b0;
      pend_div <= '0;
      p_even   <= 1'b0;
      p_odd    <= 1'b0;
      tick     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div_act  <= div_nxt;
      pend_vld <= pend_vld_nxt;
      pend_div <= pend_div_nxt;
      p_even   <= p_even_nxt;
      p_odd    <= p_odd_nxt;
      tick     <= start;
      load_err <= bus.div_load && (bus.div < DIV_W'(2));
    end
  end

  // Falling-edge stage: trims the odd-N high phase by half a source cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= p_odd;
    end
  end

  // Only one of p_even / p_odd is ever high, and both are low at every
  // boundary, so switching between even and odd ratios cannot glitch.
  assign bus.div_clk    = p_even | (p_odd & q);
  assign bus.tick       = tick;
  assign bus.div_active = div_act;
  assign bus.load_err   = load_err;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  typedef struct {
    int n;
    bit contig;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];
  int   err_q[$];

  clk_div_prog_if #(.DIV_W(8)) bus ();

  clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d (cycle %0d)", name, act, cyc);
  endtask

  task automatic push(input int n, input bit contig);
    exp_t e;
    e.n      = n;
    e.contig = contig;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_tick(input int lim);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (!bus.tick && k < lim);
    if (!bus.tick) fail("tick_timeout", k);
  endtask

  task automatic load(input int v);
    bus.div      = 8'(v);
    bus.div_load = 1'b1;
    @(posedge clk);
    #2;
    bus.div_load = 1'b0;
  endtask

  task automatic expect_err();
    err_q.push_back(cyc + 1);
  endtask

  // Period monitor: on each tick pop the expected ratio, then count high
  // half-cycle slots over the 2N slots of the period.
  initial begin
    exp_t e;
    int   hi;
    int   prev_start;
    int   prev_n;
    bit   aborted;
    prev_start = 0;
    prev_n     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.tick) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_tick", int'(bus.div_active));
        end else begin
          e = exp_q.pop_front();
          check("div_active_at_tick", int'(bus.div_active), e.n);
          if (e.contig) check("period_len", cyc - prev_start, prev_n);
          prev_start = cyc;
          prev_n     = e.n;
          hi         = int'(bus.div_clk);
          aborted    = 1'b0;
          for (int i = 1; i < 2 * e.n; i++) begin
            if (i % 2 == 1) begin
              @(negedge clk);
              #1;
            end else begin
              @(posedge clk);
              #1;
              if (rst_n) check("tick_inside_period", int'(bus.tick), 0);
            end
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            hi += int'(bus.div_clk);
          end
          if (!aborted) check("high_half_cycles", hi, e.n);
        end
      end
    end
  end

  // Load-error monitor.
  initial begin
    int c;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.load_err) begin
        if (err_q.size() == 0) begin
          fail("unexpected_load_err", cyc);
        end else begin
          c = err_q.pop_front();
          check("load_err_cycle", cyc, c);
        end
      end
    end
  end

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.div      = 8'd0;
    bus.div_load = 1'b0;
    cycles(3);
    check("rst_div_clk", int'(bus.div_clk), 0);
    check("rst_div_active", int'(bus.div_active), 8);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_load_err", int'(bus.load_err), 0);
    rst_n = 1'b1;

    // Idle with enable low: clock stays low, no ticks.
    for (int i = 0; i < 5; i++) begin
      cycles(4);
      check("idle_div_clk", int'(bus.div_clk), 0);
    end
    check("idle_div_active", int'(bus.div_active), 8);

    // Run at the default ratio, then load 3 mid-period.
    push(8, 0);
    bus.en = 1'b1;
    wait_tick(4);
    push(8, 1);
    push(8, 1);
    wait_tick(20);
    wait_tick(20);
    cycles(2);
    push(3, 1);
    load(3);
    wait_tick(20);

    // Load in the last cycle of a period: applies to the very next one.
    cycles(2);
    push(5, 1);
    load(5);
    push(5, 1);
    wait_tick(20);
    cycles(1);
    push(2, 1);
    push(2, 1);
    load(2);
    wait_tick(20);
    wait_tick(20);

    // Rejected load keeps the current ratio.
    push(2, 1);
    push(6, 1);
    expect_err();
    load(0);
    wait_tick(20);
    load(6);
    wait_tick(20);

    // Later load overwrites pending; a rejected one leaves it alone.
    cycles(1);
    push(4, 1);
    load(7);
    load(4);
    expect_err();
    load(1);
    wait_tick(20);
    check("div_active_after_overwrite", int'(bus.div_active), 4);

    // Maximum ratio.
    push(255, 1);
    load(255);
    push(6, 1);
    wait_tick(20);
    load(6);
    wait_tick(600);

    // Stop mid-period: high phase completes, then low is held.
    cycles(1);
    bus.en = 1'b0;
    cycles(1);
    check("stop_high_phase", int'(bus.div_clk), 1);
    cycles(3);
    check("stop_low_phase", int'(bus.div_clk), 0);
    cycles(1);
    for (int i = 0; i < 4; i++) begin
      cycles(3);
      check("stopped_div_clk", int'(bus.div_clk), 0);
    end

    // Restart, then drop and re-raise enable inside one period: no gap.
    push(6, 0);
    bus.en = 1'b1;
    wait_tick(4);
    push(6, 1);
    cycles(1);
    bus.en = 1'b0;
    cycles(1);
    bus.en = 1'b1;
    wait_tick(20);

    // Enable fall together with a load: ratio still applied at boundary.
    cycles(1);
    bus.en = 1'b0;
    load(3);
    cycles(3);
    cycles(1);
    check("stop_load_div_active", int'(bus.div_active), 3);
    check("stop_load_div_clk", int'(bus.div_clk), 0);

    // Asynchronous reset while the divided clock is high.
    push(3, 0);
    bus.en = 1'b1;
    wait_tick(4);
    cycles(1);
    check("odd_high_before_reset", int'(bus.div_clk), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_div_clk", int'(bus.div_clk), 0);
    check("async_rst_div_active", int'(bus.div_active), 8);
    cycles(2);
    push(8, 0);
    rst_n = 1'b1;
    wait_tick(4);
    push(8, 1);
    wait_tick(20);
    cycles(1);
    bus.en = 1'b0;
    cycles(10);
    check("exp_queue_left", exp_q.size(), 0);
    check("err_queue_left", err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
